// File: rtl/axi_slave_mem.sv
// axi_slave_mem: single-burst AXI-style responder backed by an internal RAM.
// Read bursts emulate DDR latency through a programmable first-beat delay.
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_STEP  = 2,
  parameter int MEM_AW     = 8,
  parameter int RD_LAT     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  rlast,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WDATA = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RWAIT = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [3:0]            LAT_INIT = 4'(RD_LAT - 1);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [3:0]            r_lat;
  logic                  r_rd_first;
  logic                  r_awready;
  logic                  r_arready;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [2**MEM_AW];

  logic                  w_aw_hs;
  logic                  w_ar_hs;
  logic                  w_w_hs;
  logic                  w_r_hs;
  logic                  w_w_final;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [MEM_AW-1:0]     w_rd_idx;
  logic [MEM_AW-1:0]     w_wr_idx;

  function automatic logic [MEM_AW-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
    return MEM_AW'(a / STEP);
  endfunction

  assign w_aw_hs   = (r_state == IDLE) && r_awready && awvalid;
  assign w_ar_hs   = (r_state == IDLE) && r_arready && arvalid;
  assign w_w_hs    = (r_state == WDATA) && wvalid;
  assign w_r_hs    = (r_state == RDATA) && rready;
  assign w_w_final = (r_len == 8'd0);
  assign w_wr_idx  = f_idx(r_addr);
  assign w_rd_idx  = f_idx(w_rd_addr);

  // Prefetch so the next beat is on rdata the cycle after a handshake; hold while stalled.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = r_addr;
    if (w_ar_hs) begin
      w_rd_en   = 1'b1;
      w_rd_addr = araddr;
    end else if (r_state == RWAIT) begin
      w_rd_en = 1'b1;
    end else if (w_r_hs && (r_len != 8'd0)) begin
      w_rd_en   = 1'b1;
      w_rd_addr = r_addr + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_w_hs) begin
      r_mem[w_wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_en) begin
      r_rdata <= r_mem[w_rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_lat      <= '0;
      r_rd_first <= 1'b0;
      r_awready  <= 1'b0;
      r_arready  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_addr  <= awaddr;
            r_len   <= awlen;
            r_state <= WDATA;
          end else if (w_ar_hs) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_lat   <= LAT_INIT;
            r_state <= (RD_LAT > 1) ? RWAIT : RDATA;
          end else if (!r_awready && !r_arready) begin
            // Contention goes to whichever channel did not complete last.
            if (awvalid && (!arvalid || !r_rd_first)) begin
              r_awready <= 1'b1;
            end else if (arvalid) begin
              r_arready <= 1'b1;
            end
          end
        end
        WDATA: begin
          if (wvalid) begin
            r_addr <= r_addr + STEP;
            r_len  <= r_len - 8'd1;
            if (w_w_final || wlast) begin
              r_state <= WRESP;
              if (w_w_final != wlast) begin
                r_err <= 1'b1;
              end
            end
          end
        end
        WRESP: begin
          if (bready) begin
            r_state    <= IDLE;
            r_rd_first <= 1'b1;
          end
        end
        RWAIT: begin
          if (r_lat <= 4'd1) begin
            r_state <= RDATA;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        RDATA: begin
          if (rready) begin
            if (r_len == 8'd0) begin
              r_state    <= IDLE;
              r_rd_first <= 1'b0;
            end else begin
              r_addr <= r_addr + STEP;
              r_len  <= r_len - 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign awready = r_awready;
  assign arready = r_arready;
  assign wready  = (r_state == WDATA);
  assign bvalid  = (r_state == WRESP);
  assign rvalid  = (r_state == RDATA);
  assign rlast   = (r_state == RDATA) && (r_len == 8'd0);
  assign rdata   = r_rdata;
  assign err     = r_err;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: randomized bursts checked against an
// array model of the RAM, with a decoupled R-channel monitor.
module tb_axi_slave_mem;
  localparam int AW    = 27;
  localparam int DW    = 16;
  localparam int STEP  = 2;
  localparam int MAW   = 8;
  localparam int LAT   = 4;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rlast, err, busy;
  logic          rready = 1'b0;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [DW-1:0] wdata, rdata;

  always #5 clk = ~clk;

  axi_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_STEP(STEP), .MEM_AW(MAW), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
    .err(err), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  beat_t         exp_q[$];
  beat_t         mon_beat;
  int            grant_q[$];
  bit            log_grants = 0;
  int            r_beats = 0;
  int            rready_mode = 0;
  int            rr_phase = 0;
  bit            held = 0;
  logic [DW-1:0] held_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // RAM index a beat lands in: address wraps at AW bits, index wraps at DEPTH.
  function automatic int ref_idx(input longint addr, input int beat);
    longint a;
    a = (addr + longint'(beat) * STEP) % (longint'(1) << AW);
    return int'((a / STEP) % DEPTH);
  endfunction

  always @(posedge clk) begin
    #1;
    case (rready_mode)
      0:       rready = 1'b1;
      1:       begin rready = (rr_phase % 3 == 0); rr_phase++; end
      default: rready = 1'($urandom_range(0, 1));
    endcase
  end

  // R-channel monitor: pops the scoreboard on every handshake, checks stall hold.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      held = 0;
    end else begin
      if (held && rvalid) check("r_stall_hold", rdata, held_data);
      held = 0;
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL r_unexpected_beat: got rdata=0x%0h with no beat outstanding", rdata);
        end else begin
          mon_beat = exp_q.pop_front();
          check("r_data", rdata, mon_beat.data);
          check("r_last", rlast, mon_beat.last);
        end
        r_beats++;
      end else if (rvalid) begin
        held = 1;
        held_data = rdata;
      end
      if (log_grants) begin
        if (awvalid && awready) grant_q.push_back(0);
        if (arvalid && arready) grant_q.push_back(1);
      end
    end
  end

  // wlast_at: beat index carrying wlast (-1 = never); beats after an early wlast are not sent.
  task automatic do_write(input logic [AW-1:0] addr, input int len, input int wlast_at,
                          input logic [DW-1:0] base, input bit rnd);
    int n, to;
    logic [DW-1:0] d;
    $display("WRITE addr=0x%0h len=%0d wlast_at=%0d", addr, len, wlast_at);
    awaddr = addr; awlen = len[7:0]; awvalid = 1'b1;
    to = 0;
    @(negedge clk);
    while (!awready && to < 60) begin to++; @(negedge clk); end
    if (!awready) begin awvalid = 1'b0; timeout_fail("aw_ready"); return; end
    @(posedge clk); #1 awvalid = 1'b0;
    n = (wlast_at >= 0 && wlast_at < len) ? wlast_at + 1 : len + 1;
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(posedge clk); #1;
      end
      d = rnd ? DW'($urandom) : base + DW'(i);
      wdata = d; wlast = (i == wlast_at); wvalid = 1'b1;
      to = 0;
      @(negedge clk);
      while (!wready && to < 60) begin to++; @(negedge clk); end
      if (!wready) begin wvalid = 1'b0; timeout_fail("w_ready"); return; end
      ref_mem[ref_idx(addr, i)] = d;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    check("w_ready_low_after_burst", wready, 1'b0);
    check("b_valid_asserted", bvalid, 1'b1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check("b_valid_held", bvalid, 1'b1);
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    check("b_valid_single_pulse", bvalid, 1'b0);
  endtask

  task automatic ar_phase(input logic [AW-1:0] addr, input int len, output bit ok);
    int to;
    beat_t b;
    ok = 0;
    $display("READ  addr=0x%0h len=%0d", addr, len);
    araddr = addr; arlen = len[7:0]; arvalid = 1'b1;
    to = 0;
    @(negedge clk);
    while (!arready && to < 60) begin to++; @(negedge clk); end
    if (!arready) begin arvalid = 1'b0; timeout_fail("ar_ready"); return; end
    for (int i = 0; i <= len; i++) begin
      b.data = ref_mem[ref_idx(addr, i)];
      b.last = (i == len);
      exp_q.push_back(b);
    end
    @(posedge clk); #1 arvalid = 1'b0;
    ok = 1;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len);
    int k, to;
    bit ok;
    ar_phase(addr, len, ok);
    if (!ok) return;
    k = 0;
    do begin @(negedge clk); k++; end while (!rvalid && k < LAT + 20);
    check("r_first_latency", k, LAT);
    to = 0;
    while (exp_q.size() > 0 && to < 3000) begin @(negedge clk); to++; end
    if (exp_q.size() > 0) begin timeout_fail("r_drain"); exp_q.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    int len, b0, to;
    bit ok;
    rst = 1'b1; awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0;
    awaddr = '0; araddr = '0; awlen = '0; arlen = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_awready", awready, 0); check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);   check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);   check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);     check("rst_err", err, 0);
    check("rst_busy", busy, 0);

    // Basic 8-beat write and readback.
    @(posedge clk); #1;
    do_write(27'h40, 7, 7, 16'h1000, 0);
    check("err_clean_write", err, 0);
    rready_mode = 0;
    do_read(27'h40, 7);

    // Stalled read with rready pattern 1,0,0,...
    rready_mode = 1; rr_phase = 0; b0 = r_beats;
    do_read(27'h40, 7);
    check("r_beats_toggle", r_beats - b0, 8);
    rready_mode = 0;

    // Index wrap 254,255,0,1.
    do_write(AW'((DEPTH - 2) * STEP), 3, 3, 16'hC000, 0);
    do_read(AW'((DEPTH - 2) * STEP), 3);
    do_read(27'h0, 1);

    // Round-robin when both channels request together.
    reset_dut();
    log_grants = 1; grant_q.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) do_write(AW'(32'h1000 + i * 64), 3, 3, DW'(16'hA000 + i * 16), 0);
      end
      begin
        for (int i = 0; i < 3; i++) do_read(AW'(32'h1000 + i * 64), 3);
      end
    join
    log_grants = 0;
    check("grant_count", grant_q.size(), 6);
    for (int i = 0; i < 6 && i < grant_q.size(); i++) check("grant_order", grant_q[i], i % 2);

    // Early wlast raises sticky err.
    do_write(27'h300, 7, 2, 16'hE000, 0);
    check("err_early_wlast", err, 1);
    do_write(27'h320, 3, 3, 16'hE100, 0);
    check("err_sticky", err, 1);
    do_read(27'h300, 2);

    // Reset in the middle of a read burst.
    do_write(27'h200, 7, 7, 16'h5A00, 0);
    rready_mode = 0; b0 = r_beats;
    ar_phase(27'h200, 7, ok);
    to = 0;
    while (ok && r_beats < b0 + 3 && to < 100) begin @(negedge clk); to++; end
    if (!ok || r_beats < b0 + 3) timeout_fail("r_beats_before_rst");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_rvalid", rvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_rdata", rdata, 0);
    @(posedge clk); #1;
    do_read(27'h200, 7);

    // Final beat without wlast.
    do_write(27'h380, 1, -1, 16'hB000, 0);
    check("err_missing_wlast", err, 1);
    do_read(27'h380, 1);

    // Full 256-beat burst, random data and rready.
    a = AW'($urandom);
    do_write(a, 255, 255, 16'h0, 1);
    rready_mode = 2;
    do_read(a, 255);

    // Random short bursts, including near the top of the address space.
    for (int t = 0; t < 8; t++) begin
      a = AW'($urandom);
      len = $urandom_range(0, 15);
      do_write(a, len, len, 16'h0, 1);
      rready_mode = $urandom_range(0, 2);
      do_read(a, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
